// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR-latch pulse arbiter: FSM state encoding,
// operation encoding and default parameter values.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    localparam int DEF_NREQ          = 4;
    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 2;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans req starting at ptr and returns
// the first asserted requester index together with a grant-valid flag.
module rr_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum_s     = '0;
        cand_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum_s >= (IDX_W + 1)'(NREQ)) begin
                sum_s = sum_s - (IDX_W + 1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!gnt_valid && req[cand_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/sr_pulse_arbiter_chk.sv
// Protocol checker for sr_pulse_arbiter: S and R never together, ack is
// one-hot or zero, and ack only appears while the arbiter is busy (ACK state).
module sr_pulse_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            S,
    input logic            R,
    input logic [NREQ-1:0] ack,
    input logic            busy
);

    a_no_s_and_r : assert property (@(posedge clk) disable iff (rst) !(S && R));
    a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_ack_busy   : assert property (@(posedge clk) disable iff (rst) (|ack) |-> busy);

endmodule

// File: rtl/sr_pulse_arbiter.sv
// Arbitrates NREQ requesters onto one shared SR latch. Each transaction pulses
// S or R for PULSE_CYCLES, idles both for SETTLE_CYCLES, then acks the winner.
// Optional feature macro: SR_PULSE_ARBITER_READBACK_EN enables a readback
// check of the synchronized latch output in the ACK cycle (sticky err).
module sr_pulse_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] ack,
    output logic            S,
    output logic            R,
    input  logic            Q,
    output logic            busy,
    output logic            err
);

    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_MAX = max_int(PULSE_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NREQ - 1);

    arb_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0] win_r, win_nxt_s;
    logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
    logic             op_cap_r, op_cap_nxt_s;
    logic             q_meta_r, q_sync_r;
    logic             gnt_valid_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             s_nxt_s, r_nxt_s, busy_nxt_s, err_nxt_s;
    logic [NREQ-1:0]  ack_nxt_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req),
        .ptr       (ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Next-state logic; outputs are derived from the next state so that the
    // registered S/R/ack/busy line up exactly with the state they belong to.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        win_nxt_s    = win_r;
        ptr_nxt_s    = ptr_r;
        op_cap_nxt_s = op_cap_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_nxt_s  = ST_DRIVE;
                    cnt_nxt_s    = '0;
                    win_nxt_s    = gnt_idx_s;
                    op_cap_nxt_s = op[gnt_idx_s];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_ACK;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = (win_r == LAST_IDX) ? '0 : win_r + IDX_W'(1);
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase

        // S and R are decoded from a single captured bit, so they are
        // mutually exclusive by construction.
        s_nxt_s    = (state_nxt_s == ST_DRIVE) && (op_cap_nxt_s == OP_SET);
        r_nxt_s    = (state_nxt_s == ST_DRIVE) && (op_cap_nxt_s == OP_RESET);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        ack_nxt_s  = '0;
        if (state_nxt_s == ST_ACK) begin
            ack_nxt_s[win_nxt_s] = 1'b1;
        end else begin
            ack_nxt_s = '0;
        end
    end

`ifdef SR_PULSE_ARBITER_READBACK_EN
    // Readback: latch must match the captured op when the ack is issued.
    assign err_nxt_s = err | ((state_nxt_s == ST_ACK) && (q_sync_r != op_cap_r));
`else
    // Synchronized Q has no consumer when readback is disabled.
    logic unused_q_s;
    assign unused_q_s = &{1'b0, q_sync_r};
    assign err_nxt_s  = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous latch output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_meta_r <= 1'b0;
            q_sync_r <= 1'b0;
        end else begin
            q_meta_r <= Q;
            q_sync_r <= q_meta_r;
        end
    end

    // State, transaction context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            win_r    <= '0;
            ptr_r    <= '0;
            op_cap_r <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            win_r    <= win_nxt_s;
            ptr_r    <= ptr_nxt_s;
            op_cap_r <= op_cap_nxt_s;
            S        <= s_nxt_s;
            R        <= r_nxt_s;
            ack      <= ack_nxt_s;
            busy     <= busy_nxt_s;
            err      <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_sr_pulse_arbiter.sv
// Directed, table-driven bench for sr_pulse_arbiter (default parameters).
module tb_sr_pulse_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, op, ack;
    logic            S, R, Q, busy, err;
    logic            latch_r;
    logic            q_force_en, q_force_val;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] op;
        int         exp_win;
        int         exp_s;
        int         exp_r;
        logic       exp_q;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    sr_pulse_arbiter #(.NREQ(4), .PULSE_CYCLES(2), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .ack(ack),
        .S(S), .R(R), .Q(Q), .busy(busy), .err(err)
    );

    sr_pulse_arbiter_chk #(.NREQ(4)) chk (
        .clk(clk), .rst(rst), .S(S), .R(R), .ack(ack), .busy(busy)
    );

    // Behavioural SR latch fed by the DUT; can be overridden to fake a fault.
    always @(posedge clk or posedge rst) begin
        if (rst)    latch_r <= 1'b0;
        else if (S) latch_r <= 1'b1;
        else if (R) latch_r <= 1'b0;
    end
    assign Q = q_force_en ? q_force_val : latch_r;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ack_idx(input logic [3:0] a);
        if ($countones(a) != 1) return -2;
        for (int k = 0; k < 4; k++) if (a[k]) return k;
        return -2;
    endfunction

    // One transaction: apply req/op from an IDLE cycle, observe until ack.
    task automatic run_txn(input logic [3:0] r_in, input logic [3:0] o_in,
                           output int win, output int lat, output int s_cyc,
                           output int r_cyc, output int busy_ok, output int err_ack);
        @(negedge clk);
        req = r_in; op = o_in;
        win = -1; lat = 0; s_cyc = 0; r_cyc = 0; busy_ok = 1; err_ack = 0;
        for (int c = 1; c <= 20 && win == -1; c++) begin
            @(negedge clk);
            if (S) s_cyc++;
            if (R) r_cyc++;
            if (!busy) busy_ok = 0;
            if (ack != 4'b0000) begin
                win = ack_idx(ack);
                lat = c + 1;
                err_ack = int'(err);
                req = 4'b0000;
            end
        end
        req = 4'b0000;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int win, lat, s_cyc, r_cyc, busy_ok, err_ack;
    int seq[5];
    int n_ack, s_cnt, r_cnt, stray;

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 0, 2, 0, 1'b1};
        vecs[1] = '{4'b0001, 4'b0000, 0, 0, 2, 1'b0};
        vecs[2] = '{4'b0110, 4'b0100, 1, 0, 2, 1'b0};
        vecs[3] = '{4'b1001, 4'b0000, 3, 0, 2, 1'b0};
        vecs[4] = '{4'b1001, 4'b1111, 0, 2, 0, 1'b1};
        vecs[5] = '{4'b0110, 4'b0110, 1, 2, 0, 1'b1};
        vecs[6] = '{4'b1000, 4'b1000, 3, 2, 0, 1'b1};
        vecs[7] = '{4'b1111, 4'b1010, 0, 0, 2, 1'b0};

        rst = 1'b1; req = 4'b0000; op = 4'b0000;
        q_force_en = 1'b0; q_force_val = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_S", int'(S), 0);
        check("reset_R", int'(R), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;

        // Table: pointer state carries over between rows.
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].req, vecs[v].op, win, lat, s_cyc, r_cyc, busy_ok, err_ack);
            check($sformatf("v%0d_winner", v), win, vecs[v].exp_win);
            check($sformatf("v%0d_latency", v), lat, 6);
            check($sformatf("v%0d_s_cycles", v), s_cyc, vecs[v].exp_s);
            check($sformatf("v%0d_r_cycles", v), r_cyc, vecs[v].exp_r);
            check($sformatf("v%0d_busy", v), busy_ok, 1);
            check($sformatf("v%0d_q", v), int'(Q), int'(vecs[v].exp_q));
            check($sformatf("v%0d_err", v), err_ack, 0);
            @(negedge clk);
            check($sformatf("v%0d_idle", v), int'(busy), 0);
        end

        // All four requesting continuously with reset ops: fair rotation.
        pulse_reset();
        req = 4'b1111; op = 4'b0000;
        n_ack = 0; s_cnt = 0; r_cnt = 0;
        for (int c = 0; c < 80 && n_ack < 5; c++) begin
            @(negedge clk);
            if (S) s_cnt++;
            if (R) r_cnt++;
            if (ack != 4'b0000) begin
                seq[n_ack] = ack_idx(ack);
                n_ack++;
                if (n_ack == 5) req = 4'b0000;
            end
        end
        req = 4'b0000;
        check("rr_ack_count", n_ack, 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order%0d", k), (k < n_ack) ? seq[k] : -1, k % 4);
        check("rr_s_never", s_cnt, 0);
        check("rr_r_cycles", r_cnt, 10);

        // Reset during DRIVE: outputs drop at once, transaction discarded.
        @(negedge clk);
        @(negedge clk);
        req = 4'b0001; op = 4'b0001;
        @(negedge clk);
        check("rstdrv_s_before", int'(S), 1);
        #2 rst = 1'b1;
        #1;
        check("rstdrv_S", int'(S), 0);
        check("rstdrv_R", int'(R), 0);
        check("rstdrv_busy", int'(busy), 0);
        check("rstdrv_ack", int'(ack), 0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 4'b0000 || busy) stray++;
        end
        check("rstdrv_no_ack", stray, 0);
        run_txn(4'b0011, 4'b0001, win, lat, s_cyc, r_cyc, busy_ok, err_ack);
        check("rstdrv_next_winner", win, 0);
        check("rstdrv_next_latency", lat, 6);
        check("rstdrv_next_s", s_cyc, 2);

        // Winner drops req and changes op mid-flight; non-winner also drops.
        @(negedge clk);
        @(negedge clk);
        req = 4'b0110; op = 4'b0010;
        win = -1; lat = 0; s_cyc = 0; r_cyc = 0;
        for (int c = 1; c <= 20 && win == -1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req = 4'b0100; op = 4'b0000;
            end
            if (S) s_cyc++;
            if (R) r_cyc++;
            if (ack != 4'b0000) begin
                win = ack_idx(ack);
                lat = c + 1;
                req = 4'b0000;
            end
        end
        req = 4'b0000;
        check("drop_winner", win, 1);
        check("drop_latency", lat, 6);
        check("drop_s_cycles", s_cyc, 2);
        check("drop_r_cycles", r_cyc, 0);
        @(negedge clk);

`ifdef SR_PULSE_ARBITER_READBACK_EN
        // Latch stuck low while a set runs: sticky err from the ACK cycle.
        q_force_en = 1'b1; q_force_val = 1'b0;
        run_txn(4'b0001, 4'b0001, win, lat, s_cyc, r_cyc, busy_ok, err_ack);
        check("rb_err_at_ack", err_ack, 1);
        q_force_en = 1'b0;
        run_txn(4'b0010, 4'b0000, win, lat, s_cyc, r_cyc, busy_ok, err_ack);
        check("rb_err_sticky", int'(err), 1);
        pulse_reset();
        check("rb_err_cleared", int'(err), 0);
`else
        check("noreadback_err", int'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_pulse_arbiter.md
SR_PULSE_ARBITER -- requirements
Module: sr_pulse_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter PULSE_CYCLES, default 2, cycles S or R is held high per operation (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles S=R=0 before completion (>=2, covers Q synchronizer).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request; held high until own ack.
REQ-007 op  input  NREQ  per-requester operation: 1 = set, 0 = reset; valid while req high.
REQ-008 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 S  output  1  set drive to the shared SR latch, active high.
REQ-010 R  output  1  reset drive to the shared SR latch, active high.
REQ-011 Q  input  1  latch output fed back, asynchronous to clk.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  sticky readback-mismatch flag (see Configuration).

Function
REQ-014 FSM states IDLE, DRIVE, SETTLE, ACK; S and R are registered outputs.
REQ-015 IDLE: if any req high, select winner round-robin starting at ptr, capture winner index and op[winner], go to DRIVE; else stay.
REQ-016 DRIVE: S = captured op, R = ~captured op, for exactly PULSE_CYCLES cycles, then SETTLE.
REQ-017 S and R shall never be high in the same cycle, in any state or parameterization.
REQ-018 SETTLE: S=R=0 for exactly SETTLE_CYCLES cycles, then ACK.
REQ-019 ACK: ack[winner]=1 for one cycle, ptr = winner+1 modulo NREQ, return to IDLE.
REQ-020 Request-to-ack latency from first IDLE cycle with req high: 1+PULSE_CYCLES+SETTLE_CYCLES+1 cycles (6 at defaults).
REQ-021 Requests, op changes, or req drops by non-winners during a transaction are ignored until IDLE; winner's op is not re-sampled after capture.
REQ-022 Winner dropping req mid-transaction does not abort; ack still issued.
REQ-023 Q passes through a 2-flop synchronizer before any use.
REQ-024 A requester held high after ack may win again only after all other pending requesters are served (round-robin fairness).

Reset
REQ-025 On rst: state=IDLE, S=0, R=0, ack=0, busy=0, err=0, ptr=0, synchronizer flops=0.
REQ-026 rst asserted mid-DRIVE drops S/R to 0 asynchronously; the in-flight transaction is discarded with no ack.

Configuration
REQ-027 Macro SR_PULSE_ARBITER_READBACK_EN: when defined, in ACK compare synchronized Q with captured op; mismatch sets err, cleared only by rst.
REQ-028 Without SR_PULSE_ARBITER_READBACK_EN: err tied to 0, no comparison logic; all other timing identical.

Structure
REQ-029 Package sr_arb_pkg holds the FSM state enum, op encoding constants (OP_SET=1, OP_RESET=0), and the default parameter values.
REQ-030 Sub-module rr_arbiter: combinational NREQ-wide round-robin selection from req and ptr, returning grant-valid and winner index.

Verification
REQ-031 Defaults; req=4'b0001, op=4'b0001 -> S high cycles 2-3, ack[0] at cycle 6, Q=1 afterwards.
REQ-032 req=4'b1111 held constantly, all op=0 -> acks in order 0,1,2,3,0; R pulses only, S never high.
REQ-033 ptr=2 after serving requester 1, req=4'b1001 simultaneous -> requester 3 acked before requester 0.
REQ-034 rst pulsed during DRIVE -> S=R=0 immediately, no ack, busy=0, next request completes normally.
REQ-035 READBACK_EN defined, Q forced to 0 while set op runs -> err=1 from ACK cycle, held until rst.
REQ-036 Assertion across all tests: never (S && R); ack one-hot or zero and only in ACK state.
